// File: rtl/b16_sram_bridge.sv
// Bridges 16-bit b16 core accesses onto an 8-bit asynchronous SRAM as big-endian
// byte phases (even byte = bits 15:8, odd byte = bits 7:0), stalling the core via cpu_run.
module b16_sram_bridge #(
  parameter int AW   = 16,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dbg_run,
  input  logic [15:0]   cpu_addr,
  input  logic          cpu_rd,
  input  logic [1:0]    cpu_wr,
  input  logic [15:0]   cpu_dout,
  output logic [15:0]   cpu_din,
  output logic          cpu_run,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_dq_o,
  input  logic [7:0]    mem_dq_i,
  output logic          mem_oe,
  output logic          mem_we
);

  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

  localparam logic [4:0] W = 5'(WAIT);

  state_t         state;
  logic           is_rd;
  logic [1:0]     lanes;
  logic [15:0]    wdata;
  logic [AW-2:0]  waddr;
  logic [4:0]     cnt;
  logic [4:0]     cnt_end;
  logic           req;
  logic           unused_addr_lsb;

  assign unused_addr_lsb = cpu_addr[0];
  assign req     = cpu_rd | (|cpu_wr);
  // Reads occupy WAIT+1 cycles per byte; writes add a setup and a hold cycle.
  assign cnt_end = is_rd ? W : W + 5'd1;
  // NOTE: cpu_run is combinational so the core sees the stall in the same cycle it raises req.
  assign cpu_run = ~reset & dbg_run & (~req | (state == DONE));

  always_ff @(posedge clk) begin
    // NOTE: a synchronous reset clears every register, so an in-flight access is simply dropped.
    if (reset) begin
      state    <= IDLE;
      is_rd    <= 1'b0;
      lanes    <= 2'b00;
      wdata    <= '0;
      waddr    <= '0;
      cnt      <= '0;
      cpu_din  <= '0;
      mem_addr <= '0;
      mem_dq_o <= '0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && dbg_run) begin
            is_rd  <= cpu_rd;
            lanes  <= cpu_rd ? 2'b11 : cpu_wr;
            wdata  <= cpu_dout;
            waddr  <= cpu_addr[AW-1:1];
            cnt    <= '0;
            mem_oe <= cpu_rd;
            mem_we <= 1'b0;
            if (!cpu_rd && cpu_wr == 2'b01) begin
              state    <= LO;
              mem_addr <= {cpu_addr[AW-1:1], 1'b1};
              mem_dq_o <= cpu_dout[7:0];
            end else begin
              state    <= HI;
              mem_addr <= {cpu_addr[AW-1:1], 1'b0};
              mem_dq_o <= cpu_rd ? 8'h00 : cpu_dout[15:8];
            end
          end
        end
        HI, LO: begin
          if (cnt != cnt_end) begin
            cnt <= cnt + 5'd1;
            // Write strobe spans counts 1..WAIT; count 0 is setup, WAIT+1 is hold.
            if (!is_rd) mem_we <= (cnt < W);
          end else begin
            cnt <= '0;
            if (is_rd) begin
              if (state == HI) cpu_din[15:8] <= mem_dq_i;
              else             cpu_din[7:0]  <= mem_dq_i;
            end
            if (state == HI && lanes[0]) begin
              state    <= LO;
              mem_addr <= {waddr, 1'b1};
              mem_dq_o <= wdata[7:0];
            end else begin
              state  <= DONE;
              mem_oe <= 1'b0;
            end
          end
        end
        DONE: begin
          if (dbg_run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
